// File: rtl/fb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arb_pkg
// Description : Shared types and QQVGA constants for the frame-buffer write
//               arbiter: FSM state encoding and the buffered write beat.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arb_pkg;

    localparam int QQVGA_W   = 160;
    localparam int QQVGA_H   = 120;
    localparam int FB_DEPTH  = QQVGA_W * QQVGA_H;
    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        WAIT_SWAP = 2'd2
    } fb_arb_state_e;

    // One pending pixel write; only the overlay path is buffered.
    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

endpackage
`default_nettype wire

// File: rtl/fb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter_if
// Description : Pixel write bus of the frame-buffer arbiter: downscaler
//               stream, overlay valid/ready channel and the merged fb port.
//               master = sources/frame-buffer side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_write_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              ds_we;
    logic [ADDR_W-1:0] ds_addr;
    logic [DATA_W-1:0] ds_data;
    logic              ovl_valid;
    logic              ovl_ready;
    logic [ADDR_W-1:0] ovl_addr;
    logic [DATA_W-1:0] ovl_data;
    logic              fb_we;
    logic [ADDR_W:0]   fb_addr;
    logic [DATA_W-1:0] fb_data;

    modport master (
        output ds_we, ds_addr, ds_data, ovl_valid, ovl_addr, ovl_data,
        input  ovl_ready, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  ds_we, ds_addr, ds_data, ovl_valid, ovl_addr, ovl_data,
        output ovl_ready, fb_we, fb_addr, fb_data
    );
endinterface
`default_nettype wire

// File: rtl/fb_ovl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_ovl_fifo
// Description : Synchronous FIFO of overlay write beats. A push is accepted
//               when full if a pop happens in the same cycle. DEPTH must be
//               a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_ovl_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_push,
    input  fb_wr_t    i_push_data,
    input  wire logic i_pop,
    output fb_wr_t    o_head,
    output logic      o_full,
    output logic      o_empty
);
    localparam int c_PTR_W = $clog2(DEPTH);

    fb_wr_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_write_arbiter
// Description : Owns the write port of the double-banked QQVGA frame buffer.
//               Merges the never-stalled downscaler stream with buffered
//               overlay beats, swaps banks on the display vsync and drops
//               capture frames while the display still holds the bank.
//               Optional macro FB_DROP_COUNT_EN enables the dropped-frame
//               counter; otherwise dropped_frames is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 16,
    parameter int FB_DEPTH       = fb_arb_pkg::FB_DEPTH,
    parameter int OVL_FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          frame_start,
    input  wire logic          ovl_frame_done,
    input  wire logic          disp_vsync,
    fb_write_arbiter_if.slave  bus,
    output logic               disp_bank,
    output logic               addr_err,
    output logic [7:0]         dropped_frames
);
    import fb_arb_pkg::*;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    fb_arb_state_e     r_state;
    fb_arb_state_e     w_state_nxt;
    logic              r_ds_last_seen;
    logic              w_ds_last_seen_nxt;
    logic              r_ovl_done_seen;
    logic              w_ovl_done_seen_nxt;
    logic              w_swap;
    logic              r_wr_bank;
    logic              r_disp_bank;
    logic              r_addr_err;
    logic              r_fb_we;
    logic [ADDR_W:0]   r_fb_addr;
    logic [DATA_W-1:0] r_fb_data;

    logic   w_ds_hit;
    logic   w_ds_ok;
    logic   w_ovl_acc;
    logic   w_ovl_ok;
    logic   w_pop;
    logic   w_addr_bad;
    logic   w_fifo_full;
    logic   w_fifo_empty;
    fb_wr_t w_push_data;
    fb_wr_t w_head;

    // Downscaler writes only count in CAPTURE; out-of-range ones neither
    // write nor take the port, so the overlay may use that slot.
    assign w_ds_hit   = (r_state == CAPTURE) && bus.ds_we;
    assign w_ds_ok    = w_ds_hit && (bus.ds_addr <= c_LAST_ADDR);
    assign w_ovl_acc  = bus.ovl_valid && bus.ovl_ready;
    assign w_ovl_ok   = w_ovl_acc && (bus.ovl_addr <= c_LAST_ADDR);
    assign w_pop      = !w_ds_ok && !w_fifo_empty;
    assign w_addr_bad = (w_ds_hit && !w_ds_ok) || (w_ovl_acc && !w_ovl_ok);

    assign bus.ovl_ready = (r_state == CAPTURE) && !w_fifo_full;
    assign w_push_data   = '{addr: bus.ovl_addr, data: bus.ovl_data};

    fb_ovl_fifo #(
        .DEPTH (OVL_FIFO_DEPTH)
    ) u_ovl_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_ovl_ok),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Frame sequencing: capture, wait for both sources to finish, then
    // hold the completed bank until the display frame boundary.
    always_comb begin
        w_state_nxt         = r_state;
        w_ds_last_seen_nxt  = r_ds_last_seen;
        w_ovl_done_seen_nxt = r_ovl_done_seen;
        w_swap              = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_state_nxt         = CAPTURE;
                    w_ds_last_seen_nxt  = 1'b0;
                    w_ovl_done_seen_nxt = 1'b0;
                end
            end
            CAPTURE: begin
                if (frame_start) begin
                    w_ds_last_seen_nxt  = 1'b0;
                    w_ovl_done_seen_nxt = 1'b0;
                end else begin
                    if (w_ds_ok && (bus.ds_addr == c_LAST_ADDR)) w_ds_last_seen_nxt = 1'b1;
                    if (ovl_frame_done) w_ovl_done_seen_nxt = 1'b1;
                    // A beat accepted this cycle must land before the swap.
                    if (r_ds_last_seen && r_ovl_done_seen && w_fifo_empty && !w_ovl_acc) begin
                        w_state_nxt = WAIT_SWAP;
                    end
                end
            end
            WAIT_SWAP: begin
                if (disp_vsync) begin
                    w_swap      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, completion flags, bank ownership and the sticky range error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_ds_last_seen  <= 1'b0;
            r_ovl_done_seen <= 1'b0;
            r_wr_bank       <= 1'b0;
            r_disp_bank     <= 1'b1;
            r_addr_err      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ds_last_seen  <= w_ds_last_seen_nxt;
            r_ovl_done_seen <= w_ovl_done_seen_nxt;
            if (w_swap) begin
                r_disp_bank <= r_wr_bank;
                r_wr_bank   <= ~r_wr_bank;
            end
            if (w_addr_bad) r_addr_err <= 1'b1;
        end
    end

    // Registered write port: downscaler first, else the overlay FIFO head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else if (w_ds_ok) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= {r_wr_bank, bus.ds_addr};
            r_fb_data <= bus.ds_data;
        end else if (w_pop) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= {r_wr_bank, w_head.addr};
            r_fb_data <= w_head.data;
        end else begin
            r_fb_we   <= 1'b0;
        end
    end

    assign bus.fb_we   = r_fb_we;
    assign bus.fb_addr = r_fb_addr;
    assign bus.fb_data = r_fb_data;
    assign disp_bank   = r_disp_bank;
    assign addr_err    = r_addr_err;

`ifdef FB_DROP_COUNT_EN
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    assign w_drop = (r_state == WAIT_SWAP) && frame_start;

    // Saturating count of capture frames that found no free bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign dropped_frames = r_drop_cnt;
`else
    assign dropped_frames = 8'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_write_arbiter
// Description : Directed self-checking bench for fb_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fb_write_arbiter;

`ifdef FB_DROP_COUNT_EN
    localparam logic [7:0] c_EXP_DROP = 8'd1;
`else
    localparam logic [7:0] c_EXP_DROP = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic       ovl_frame_done;
    logic       disp_vsync;
    logic       disp_bank;
    logic       addr_err;
    logic [7:0] dropped_frames;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fb_write_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

    fb_write_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_start    (frame_start),
        .ovl_frame_done (ovl_frame_done),
        .disp_vsync     (disp_vsync),
        .bus            (bus),
        .disp_bank      (disp_bank),
        .addr_err       (addr_err),
        .dropped_frames (dropped_frames)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        frame_start    = 1'b0;
        ovl_frame_done = 1'b0;
        disp_vsync     = 1'b0;
        bus.ds_we      = 1'b0;
        bus.ds_addr    = '0;
        bus.ds_data    = '0;
        bus.ovl_valid  = 1'b0;
        bus.ovl_addr   = '0;
        bus.ovl_data   = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++; if (bus.fb_we !== 1'b0)       begin errors++; $display("FAIL rst_fb_we: got %0b required 0", bus.fb_we); end
        checks++; if (bus.fb_addr !== 16'h0)    begin errors++; $display("FAIL rst_fb_addr: got %0h required 0", bus.fb_addr); end
        checks++; if (bus.fb_data !== 16'h0)    begin errors++; $display("FAIL rst_fb_data: got %0h required 0", bus.fb_data); end
        checks++; if (disp_bank !== 1'b1)       begin errors++; $display("FAIL rst_disp_bank: got %0b required 1", disp_bank); end
        checks++; if (addr_err !== 1'b0)        begin errors++; $display("FAIL rst_addr_err: got %0b required 0", addr_err); end
        checks++; if (dropped_frames !== 8'd0)  begin errors++; $display("FAIL rst_dropped: got %0d required 0", dropped_frames); end
        checks++; if (bus.ovl_ready !== 1'b0)   begin errors++; $display("FAIL rst_ovl_ready: got %0b required 0", bus.ovl_ready); end
        reset_n = 1'b1;
        tick();
        checks++; if (bus.ovl_ready !== 1'b0)   begin errors++; $display("FAIL idle_ovl_ready: got %0b required 0", bus.ovl_ready); end
    endtask

    // Full 19200-pixel frame into bank 0, then both sources done -> WAIT_SWAP.
    task automatic test_full_frame();
        int bad = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            bus.ds_we   = 1'b1;
            bus.ds_addr = 15'(i);
            bus.ds_data = 16'(i) ^ 16'h5A5A;
            tick();
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== {1'b0, 15'(i)} || bus.fb_data !== (16'(i) ^ 16'h5A5A)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL frame0_writes: got %0d bad beats required 0", bad); end
        bus.ds_we      = 1'b0;
        ovl_frame_done = 1'b1;
        tick();
        ovl_frame_done = 1'b0;
        checks++; if (bus.fb_we !== 1'b0)     begin errors++; $display("FAIL frame0_idle_we: got %0b required 0", bus.fb_we); end
        checks++; if (bus.ovl_ready !== 1'b1) begin errors++; $display("FAIL frame0_capture_ready: got %0b required 1", bus.ovl_ready); end
        tick();
        checks++; if (bus.ovl_ready !== 1'b0) begin errors++; $display("FAIL wait_swap_ready: got %0b required 0", bus.ovl_ready); end
        checks++; if (disp_bank !== 1'b1)     begin errors++; $display("FAIL wait_swap_disp_bank: got %0b required 1", disp_bank); end
    endtask

    // frame_start while the finished bank is still unreleased drops the frame.
    task automatic test_drop();
        int wes = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.ds_we   = 1'b1;
            bus.ds_addr = 15'(i);
            bus.ds_data = 16'hBEEF;
            tick();
            if (bus.fb_we !== 1'b0) wes++;
        end
        bus.ds_we = 1'b0;
        checks++; if (wes !== 0)                     begin errors++; $display("FAIL drop_no_writes: got %0d writes required 0", wes); end
        checks++; if (dropped_frames !== c_EXP_DROP) begin errors++; $display("FAIL drop_count: got %0d required %0d", dropped_frames, c_EXP_DROP); end
        checks++; if (disp_bank !== 1'b1)            begin errors++; $display("FAIL drop_disp_bank: got %0b required 1", disp_bank); end
    endtask

    // vsync hands bank 0 to the display; next frame lands in bank 1.
    task automatic test_swap();
        logic [14:0] addrs [3];
        addrs[0] = 15'd0; addrs[1] = 15'd1; addrs[2] = 15'd19199;
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
        checks++; if (disp_bank !== 1'b0) begin errors++; $display("FAIL swap1_disp_bank: got %0b required 0", disp_bank); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ds_we   = 1'b1;
            bus.ds_addr = addrs[i];
            bus.ds_data = 16'h7000 + 16'(i);
            tick();
            checks++;
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== {1'b1, addrs[i]} || bus.fb_data !== (16'h7000 + 16'(i))) begin
                errors++;
                $display("FAIL frame1_write%0d: got we=%0b addr=%0h data=%0h required we=1 addr=%0h data=%0h",
                         i, bus.fb_we, bus.fb_addr, bus.fb_data, {1'b1, addrs[i]}, 16'h7000 + 16'(i));
            end
        end
        bus.ds_we      = 1'b0;
        ovl_frame_done = 1'b1;
        tick();
        ovl_frame_done = 1'b0;
        tick();
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
        checks++; if (disp_bank !== 1'b1) begin errors++; $display("FAIL swap2_disp_bank: got %0b required 1", disp_bank); end
    endtask

    // Overlay beats with the downscaler idle: 2-cycle latency, in order.
    task automatic test_overlay();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        bus.ovl_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.ovl_addr = 15'(100 + k);
            bus.ovl_data = 16'hC000 + 16'(k);
            checks++; if (bus.ovl_ready !== 1'b1) begin errors++; $display("FAIL ovl_ready%0d: got %0b required 1", k, bus.ovl_ready); end
            tick();
            checks++;
            if (k == 0) begin
                if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL ovl_latency: got we=%0b required 0", bus.fb_we); end
            end else if (bus.fb_we !== 1'b1 || bus.fb_addr !== {1'b0, 15'(99 + k)} || bus.fb_data !== (16'hC000 + 16'(k - 1))) begin
                errors++;
                $display("FAIL ovl_beat%0d: got we=%0b addr=%0h data=%0h", k - 1, bus.fb_we, bus.fb_addr, bus.fb_data);
            end
        end
        bus.ovl_valid = 1'b0;
        tick();
        checks++;
        if (bus.fb_we !== 1'b1 || bus.fb_addr !== {1'b0, 15'd103} || bus.fb_data !== 16'hC003) begin
            errors++; $display("FAIL ovl_beat3: got we=%0b addr=%0h data=%0h", bus.fb_we, bus.fb_addr, bus.fb_data);
        end
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL ovl_drained: got %0b required 0", bus.fb_we); end
        disp_vsync = 1'b1;
        tick();
        disp_vsync = 1'b0;
        checks++; if (disp_bank !== 1'b1)     begin errors++; $display("FAIL vsync_in_capture_bank: got %0b required 1", disp_bank); end
        checks++; if (bus.ovl_ready !== 1'b1) begin errors++; $display("FAIL vsync_in_capture_ready: got %0b required 1", bus.ovl_ready); end
    endtask

    // Continuous downscaler traffic starves the overlay; it drains afterwards.
    task automatic test_back_to_back();
        int bad_ds = 0;
        int bad_rdy = 0;
        for (int i = 0; i < 100; i++) begin
            bus.ds_we     = 1'b1;
            bus.ds_addr   = 15'(200 + i);
            bus.ds_data   = 16'h1000 + 16'(i);
            bus.ovl_valid = (i < 4);
            bus.ovl_addr  = 15'(300 + i);
            bus.ovl_data  = 16'hE000 + 16'(i);
            if (bus.ovl_ready !== ((i < 4) ? 1'b1 : 1'b0)) bad_rdy++;
            tick();
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== {1'b0, 15'(200 + i)} || bus.fb_data !== (16'h1000 + 16'(i))) bad_ds++;
        end
        bus.ds_we     = 1'b0;
        bus.ovl_valid = 1'b0;
        checks++; if (bad_ds !== 0)  begin errors++; $display("FAIL burst_ds_only: got %0d bad beats required 0", bad_ds); end
        checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL burst_ready_full: got %0d bad cycles required 0", bad_rdy); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.fb_we !== 1'b1 || bus.fb_addr !== {1'b0, 15'(300 + k)} || bus.fb_data !== (16'hE000 + 16'(k))) begin
                errors++;
                $display("FAIL drain_beat%0d: got we=%0b addr=%0h data=%0h required addr=%0h data=%0h",
                         k, bus.fb_we, bus.fb_addr, bus.fb_data, {1'b0, 15'(300 + k)}, 16'hE000 + 16'(k));
            end
        end
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL drain_done: got %0b required 0", bus.fb_we); end
    endtask

    // Out-of-range overlay address is accepted but never written.
    task automatic test_ovl_addr_err();
        bus.ovl_valid = 1'b1;
        bus.ovl_addr  = 15'd32767;
        bus.ovl_data  = 16'hDEAD;
        tick();
        bus.ovl_valid = 1'b0;
        checks++; if (addr_err !== 1'b1)  begin errors++; $display("FAIL ovl_addr_err: got %0b required 1", addr_err); end
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL ovl_bad_we0: got %0b required 0", bus.fb_we); end
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL ovl_bad_we1: got %0b required 0", bus.fb_we); end
        bus.ds_we   = 1'b1;
        bus.ds_addr = 15'd19200;
        tick();
        bus.ds_we = 1'b0;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL ds_bad_we_sticky: got %0b required 0", bus.fb_we); end
    endtask

    // Asynchronous reset in the middle of a capture with queued overlay beats.
    task automatic test_reset_mid();
        int wes = 0;
        for (int i = 0; i < 3; i++) begin
            bus.ds_we     = 1'b1;
            bus.ds_addr   = 15'(400 + i);
            bus.ovl_valid = 1'b1;
            bus.ovl_addr  = 15'(500 + i);
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.fb_we !== 1'b0)      begin errors++; $display("FAIL mid_rst_we: got %0b required 0", bus.fb_we); end
        checks++; if (bus.fb_addr !== 16'h0)   begin errors++; $display("FAIL mid_rst_addr: got %0h required 0", bus.fb_addr); end
        checks++; if (bus.fb_data !== 16'h0)   begin errors++; $display("FAIL mid_rst_data: got %0h required 0", bus.fb_data); end
        checks++; if (bus.ovl_ready !== 1'b0)  begin errors++; $display("FAIL mid_rst_ready: got %0b required 0", bus.ovl_ready); end
        checks++; if (addr_err !== 1'b0)       begin errors++; $display("FAIL mid_rst_addr_err: got %0b required 0", addr_err); end
        checks++; if (dropped_frames !== 8'd0) begin errors++; $display("FAIL mid_rst_dropped: got %0d required 0", dropped_frames); end
        checks++; if (disp_bank !== 1'b1)      begin errors++; $display("FAIL mid_rst_disp_bank: got %0b required 1", disp_bank); end
        idle_inputs();
        #2;
        reset_n = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++; if (bus.ovl_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b required 1", bus.ovl_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.fb_we !== 1'b0) wes++;
        end
        checks++; if (wes !== 0) begin errors++; $display("FAIL post_rst_fifo_empty: got %0d writes required 0", wes); end
    endtask

    // Out-of-range downscaler address from a clean error state.
    task automatic test_ds_addr_err();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL ds_err_pre: got %0b required 0", addr_err); end
        bus.ds_we   = 1'b1;
        bus.ds_addr = 15'd19200;
        bus.ds_data = 16'hFFFF;
        tick();
        bus.ds_we = 1'b0;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL ds_bad_we: got %0b required 0", bus.fb_we); end
        checks++; if (addr_err !== 1'b1)  begin errors++; $display("FAIL ds_addr_err: got %0b required 1", addr_err); end
        repeat (3) tick();
        checks++; if (addr_err !== 1'b1)  begin errors++; $display("FAIL ds_addr_err_sticky: got %0b required 1", addr_err); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_drop();
        test_swap();
        test_overlay();
        test_back_to_back();
        test_ovl_addr_err();
        test_reset_mid();
        test_ds_addr_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
